// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit-validity helper for the
// BCD <-> binary converters.
package bcd_pkg;

    localparam int unsigned NDIG    = 5;
    localparam int unsigned NBITS   = 16;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic digits_invalid(input logic [4*NDIG-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > BCD_MAX) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: a digit of 8 or more after the
// right shift had a borrowed "10" folded in as 8 and is brought back by -3.
module bcd_digit_corr (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= 4'd8) q = d - 4'd3;
    end

endmodule

// File: rtl/bcd2bin_16.sv
// Sequential 5-digit BCD to 16-bit binary converter (reverse double-dabble,
// one shift and correction per clock) with start/busy/done handshake.
module bcd2bin_16
    import bcd_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  BCD0,
    input  logic [3:0]  BCD1,
    input  logic [3:0]  BCD2,
    input  logic [3:0]  BCD3,
    input  logic [3:0]  BCD4,
    output logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        err
);

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [NBITS-1:0]    res_q, res_d;
    logic [NBITS-1:0]    bin_q, bin_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic [4*NDIG-1:0]   bcd_in;
    logic [4*NDIG-1:0]   bcd_sh;
    logic [4*NDIG-1:0]   bcd_corr;

    assign bcd_in = {BCD4, BCD3, BCD2, BCD1, BCD0};
    assign bcd_sh = bcd_q >> 1;

    for (genvar g = 0; g < NDIG; g++) begin : gen_corr
        bcd_digit_corr u_corr (
            .d (bcd_sh[4*g +: 4]),
            .q (bcd_corr[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        res_d   = res_q;
        bin_d   = bin_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = digits_invalid(bcd_in);
                    state_d = digits_invalid(bcd_in) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_corr;
                res_d = {bcd_q[0], res_q[NBITS-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(NBITS - 1)) state_d = DONE;
            end
            DONE: begin
                // Outputs are registered on the DONE edge, so the done pulse
                // lands in the first IDLE cycle; an error run never shifted.
                bin_d   = err_q ? '0 : res_q;
                ovf_d   = !err_q && (bcd_q != '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            res_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            res_q   <= res_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bin  = bin_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Self-checking bench for bcd2bin_16: directed corner cases, handshake and
// reset behaviour, then random digits against an arithmetic reference.
module tb_bcd2bin_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  BCD0, BCD1, BCD2, BCD3, BCD4;
    logic [15:0] bin;
    logic        busy, done, ovf, err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    bcd2bin_16 dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .BCD0     (BCD0),
        .BCD1     (BCD1),
        .BCD2     (BCD2),
        .BCD3     (BCD3),
        .BCD4     (BCD4),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " bin"},  32'(bin),  32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " ovf"},  32'(ovf),  32'd0);
        chk({tag, " err"},  32'(err),  32'd0);
    endtask

    // Reference: decimal value by plain arithmetic; invalid if any digit > 9.
    task automatic model(input logic [3:0] d4, d3, d2, d1, d0,
                         output logic [15:0] e_bin, output logic e_ovf,
                         output logic e_err, output int e_lat);
        int unsigned val;
        val   = d4 * 10000 + d3 * 1000 + d2 * 100 + d1 * 10 + d0;
        e_err = (d4 > 9) || (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
        e_bin = e_err ? 16'd0 : val[15:0];
        e_ovf = !e_err && (val > 65535);
        e_lat = e_err ? 1 : 17;
    endtask

    task automatic run_conv(input logic [3:0] d4, d3, d2, d1, d0, input string tag);
        logic [15:0] e_bin;
        logic        e_ovf, e_err;
        int          e_lat, lat;
        model(d4, d3, d2, d1, d0, e_bin, e_ovf, e_err, e_lat);
        @(negedge clk);
        {BCD4, BCD3, BCD2, BCD1, BCD0} = {d4, d3, d2, d1, d0};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        {BCD4, BCD3, BCD2, BCD1, BCD0} = 20'($urandom);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (done) lat = c;
        end
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " bin"}, 32'(bin), 32'(e_bin));
        chk({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, " err"}, 32'(err), 32'(e_err));
        @(posedge clk);
        #1;
        chk({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          pulses, lat;
        logic [3:0]  r [5];
        reset = 1'b1;
        start = 1'b0;
        {BCD4, BCD3, BCD2, BCD1, BCD0} = '0;
        #2;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_conv(0, 0, 0, 0, 0, "zero");
        run_conv(6, 5, 5, 3, 5, "65535");
        run_conv(6, 5, 5, 3, 6, "65536");
        run_conv(9, 9, 9, 9, 9, "99999");
        run_conv(1, 2, 4'hA, 3, 4, "bad hundreds");

        // Second start mid-conversion must be dropped, not queued.
        @(negedge clk);
        {BCD4, BCD3, BCD2, BCD1, BCD0} = {4'd0, 4'd4, 4'd3, 4'd2, 4'd1};
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        lat    = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start = 1'b1;
                {BCD4, BCD3, BCD2, BCD1, BCD0} = {5{4'd9}};
            end
            if (c == 6) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (lat == 0) lat = c;
            end
        end
        chk("ignored start pulses", 32'(pulses), 32'd1);
        chk("ignored start latency", 32'(lat), 32'd17);
        chk("ignored start bin", 32'(bin), 32'd4321);

        // Start held high re-triggers on the done cycle.
        @(negedge clk);
        {BCD4, BCD3, BCD2, BCD1, BCD0} = {4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (done) lat = c;
        end
        chk("held start first done", 32'(lat), 32'd17);
        @(posedge clk);
        #1;
        chk("held start retrigger busy", 32'(busy), 32'd1);
        start = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (done) lat = c;
        end
        chk("held start second done", 32'(lat), 32'd17);
        chk("held start bin", 32'(bin), 32'd42);
        @(posedge clk);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        {BCD4, BCD3, BCD2, BCD1, BCD0} = {4'd0, 4'd0, 4'd7, 4'd7, 4'd7};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid reset");
        @(negedge clk);
        reset = 1'b0;
        run_conv(1, 2, 3, 4, 5, "12345 after reset");

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 5; j++)
                r[j] = (i % 8 == 7) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            run_conv(r[4], r[3], r[2], r[1], r[0], $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
